// File: rtl/ysyx_22041461_hazard_unit.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_hazard_unit
// Hazard and stall controller for the 5-stage RV64 pipeline (IF/ID/EXE/MEM/WB).
//
// Keeps a shadow copy of the destination-register info for EXE/MEM/WB.
// The copy advances with the same enable/bubble controls this unit drives.
// From that copy and the ID-stage operands it detects:
//   - GPR RAW hazards
//   - CSR serialisation hazards
// It also arbitrates busy stalls, branch redirect and trap flush.
//
// Optional feature macro: YSYX_22041461_FWD_EN
//   defined   : ALU results forward from EXE/MEM/WB.
//               Only a load in EXE stalls a dependent instruction.
//   undefined : fwd selects are tied to 0.
//               Any in-flight producer stalls its consumer.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   ID_*                 operand / destination info of the instruction in ID
//   EXE_busy, MEM_busy   multi-cycle unit not done
//   EXE_redirect         taken branch/jump resolved in EXE
//   trap_flush           trap/mret taken in WB
//   *_enable             pipeline register update enables
//   ID_flush, *_bubble   bubble insertion into pipeline registers
//   fwd_rs1/2_sel        0 regfile, 1 EXE, 2 MEM, 3 WB
//   stall_cnt            saturating count of hazard stall cycles
// ---------------------------------------------------------------------------
module ysyx_22041461_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CSR_AW = 12,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_valid,
  input  logic              ID_rs1_read,
  input  logic              ID_rs2_read,
  input  logic [REG_AW-1:0] ID_rs1,
  input  logic [REG_AW-1:0] ID_rs2,
  input  logic              ID_rd_write,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic              ID_is_load,
  input  logic              ID_csr_read,
  input  logic              ID_csr_write,
  input  logic              EXE_busy,
  input  logic              MEM_busy,
  input  logic              EXE_redirect,
  input  logic              trap_flush,
  output logic              IF_enable,
  output logic              ID_enable,
  output logic              ID_flush,
  output logic              EXE_enable,
  output logic              EXE_bubble,
  output logic              MEM_enable,
  output logic              MEM_bubble,
  output logic              WB_enable,
  output logic              WB_bubble,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  if (CSR_AW < 1 || REG_AW < 1 || CNT_W < 1) begin : g_bad_params
    $error("hazard_unit: REG_AW, CSR_AW and CNT_W must be positive");
  end

  typedef struct packed {
    logic              valid;
    logic              rd_write;
    logic [REG_AW-1:0] rd;
    logic              is_load;
    logic              csr_write;
  } sh_t;

  typedef enum logic [2:0] {
    MODE_TRAP, MODE_MEM_BUSY, MODE_EXE_BUSY, MODE_REDIRECT, MODE_HAZARD, MODE_RUN
  } mode_t;

  sh_t              r_sh_exe, r_sh_mem, r_sh_wb;
  logic             r_pend_redir;
  logic [CNT_W-1:0] r_stall_cnt;

  sh_t   w_id_entry;
  mode_t w_mode;
  logic  w_m1_exe, w_m1_mem, w_m1_wb;
  logic  w_m2_exe, w_m2_mem, w_m2_wb;
  logic  w_data_haz, w_csr_haz;
  logic [1:0] w_sel1, w_sel2;
  logic  w_unused_wb_load;

  function automatic logic f_match(input sh_t e, input logic [REG_AW-1:0] rs);
    return e.valid & e.rd_write & (e.rd == rs) & (rs != '0);
  endfunction

  // Youngest producer wins: EXE > MEM > WB.
  function automatic logic [1:0] f_sel(input logic m_exe, input logic m_mem, input logic m_wb);
    if (m_exe)      return 2'd1;
    else if (m_mem) return 2'd2;
    else if (m_wb)  return 2'd3;
    else            return 2'd0;
  endfunction

  // Fields are masked with ID_valid, so a non-instruction never looks like a producer.
  assign w_id_entry = '{valid:     ID_valid,
                        rd_write:  ID_valid & ID_rd_write,
                        rd:        ID_rd,
                        is_load:   ID_valid & ID_is_load,
                        csr_write: ID_valid & ID_csr_write};

  assign w_m1_exe = ID_rs1_read & f_match(r_sh_exe, ID_rs1);
  assign w_m1_mem = ID_rs1_read & f_match(r_sh_mem, ID_rs1);
  assign w_m1_wb  = ID_rs1_read & f_match(r_sh_wb,  ID_rs1);
  assign w_m2_exe = ID_rs2_read & f_match(r_sh_exe, ID_rs2);
  assign w_m2_mem = ID_rs2_read & f_match(r_sh_mem, ID_rs2);
  assign w_m2_wb  = ID_rs2_read & f_match(r_sh_wb,  ID_rs2);

`ifdef YSYX_22041461_FWD_EN
  assign w_data_haz = (w_m1_exe | w_m2_exe) & r_sh_exe.is_load;
  assign w_sel1     = f_sel(w_m1_exe, w_m1_mem, w_m1_wb);
  assign w_sel2     = f_sel(w_m2_exe, w_m2_mem, w_m2_wb);
`else
  // The regfile is written at the end of WB, so even a WB producer must be waited out.
  assign w_data_haz = w_m1_exe | w_m1_mem | w_m1_wb | w_m2_exe | w_m2_mem | w_m2_wb;
  assign w_sel1     = 2'd0;
  assign w_sel2     = 2'd0;
`endif

  assign w_csr_haz = (ID_csr_read | ID_csr_write) &
                     ((r_sh_exe.valid & r_sh_exe.csr_write) |
                      (r_sh_mem.valid & r_sh_mem.csr_write) |
                      (r_sh_wb.valid  & r_sh_wb.csr_write));

  // The load flag is only consulted in EXE; the WB copy just retires.
  assign w_unused_wb_load = r_sh_wb.is_load;

  always_comb begin
    if (trap_flush)                        w_mode = MODE_TRAP;
    else if (MEM_busy)                     w_mode = MODE_MEM_BUSY;
    else if (EXE_busy)                     w_mode = MODE_EXE_BUSY;
    else if (EXE_redirect | r_pend_redir)  w_mode = MODE_REDIRECT;
    else if (ID_valid & (w_data_haz | w_csr_haz)) w_mode = MODE_HAZARD;
    else                                   w_mode = MODE_RUN;
  end

  always_comb begin
    IF_enable   = 1'b1;
    ID_enable   = 1'b1;
    EXE_enable  = 1'b1;
    MEM_enable  = 1'b1;
    WB_enable   = 1'b1;
    ID_flush    = 1'b0;
    EXE_bubble  = 1'b0;
    MEM_bubble  = 1'b0;
    WB_bubble   = 1'b0;
    fwd_rs1_sel = 2'd0;
    fwd_rs2_sel = 2'd0;
    unique case (w_mode)
      MODE_TRAP: begin
        ID_flush   = 1'b1;
        EXE_bubble = 1'b1;
        MEM_bubble = 1'b1;
        WB_bubble  = 1'b1;
      end
      MODE_MEM_BUSY: begin
        IF_enable  = 1'b0;
        ID_enable  = 1'b0;
        EXE_enable = 1'b0;
        MEM_enable = 1'b0;
        WB_bubble  = 1'b1;
      end
      MODE_EXE_BUSY: begin
        IF_enable  = 1'b0;
        ID_enable  = 1'b0;
        EXE_enable = 1'b0;
        MEM_bubble = 1'b1;
      end
      MODE_REDIRECT: begin
        ID_flush   = 1'b1;
        EXE_bubble = 1'b1;
      end
      MODE_HAZARD: begin
        IF_enable  = 1'b0;
        ID_enable  = 1'b0;
        EXE_bubble = 1'b1;
      end
      default: begin
        if (ID_valid) begin
          fwd_rs1_sel = w_sel1;
          fwd_rs2_sel = w_sel2;
        end
      end
    endcase
  end

  assign stall_cnt = r_stall_cnt;

  // The shadow follows the same enable/bubble controls the pipeline registers see.
  // A bubble overrides an enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh_exe     <= '0;
      r_sh_mem     <= '0;
      r_sh_wb      <= '0;
      r_pend_redir <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      if (EXE_bubble)      r_sh_exe <= '0;
      else if (EXE_enable) r_sh_exe <= w_id_entry;
      if (MEM_bubble)      r_sh_mem <= '0;
      else if (MEM_enable) r_sh_mem <= r_sh_exe;
      if (WB_bubble)       r_sh_wb  <= '0;
      else if (WB_enable)  r_sh_wb  <= r_sh_mem;

      // A redirect arriving while MEM is frozen is remembered.
      // It is replayed once the pipeline moves again.
      unique case (w_mode)
        MODE_TRAP, MODE_REDIRECT: r_pend_redir <= 1'b0;
        MODE_MEM_BUSY:            r_pend_redir <= r_pend_redir | EXE_redirect;
        default:                  r_pend_redir <= r_pend_redir;
      endcase

      if (w_mode == MODE_HAZARD && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_hazard_unit.sv
module tb_ysyx_22041461_hazard_unit;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, ID_valid, ID_rs1_read, ID_rs2_read, ID_rd_write, ID_is_load;
  logic       ID_csr_read, ID_csr_write, EXE_busy, MEM_busy, EXE_redirect, trap_flush;
  logic [4:0] ID_rs1, ID_rs2, ID_rd;
  logic       IF_enable, ID_enable, ID_flush, EXE_enable, EXE_bubble;
  logic       MEM_enable, MEM_bubble, WB_enable, WB_bubble;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [CW-1:0] stall_cnt;

  ysyx_22041461_hazard_unit #(.REG_AW(5), .CSR_AW(12), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_rs1_read(ID_rs1_read),
    .ID_rs2_read(ID_rs2_read), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rd_write(ID_rd_write), .ID_rd(ID_rd), .ID_is_load(ID_is_load),
    .ID_csr_read(ID_csr_read), .ID_csr_write(ID_csr_write), .EXE_busy(EXE_busy),
    .MEM_busy(MEM_busy), .EXE_redirect(EXE_redirect), .trap_flush(trap_flush),
    .IF_enable(IF_enable), .ID_enable(ID_enable), .ID_flush(ID_flush),
    .EXE_enable(EXE_enable), .EXE_bubble(EXE_bubble), .MEM_enable(MEM_enable),
    .MEM_bubble(MEM_bubble), .WB_enable(WB_enable), .WB_bubble(WB_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit rst, valid, r1, r2, wr, ld, cr, cw, eb, mb, redir, trap;
    int rs1, rs2, rd;
  } stim_t;

  typedef struct {
    bit [8:0] ctrl;  // {IF_en, ID_en, ID_flush, EXE_en, EXE_bub, MEM_en, MEM_bub, WB_en, WB_bub}
    int f1, f2, cnt;
  } exp_t;

  typedef struct { bit v, wr, ld, cw; int rd; } ins_t;

  // Reference model: the instructions in flight, [0]=EXE, [1]=MEM, [2]=WB.
  ins_t pipe[3];
  bit   m_pend;
  int   m_cnt;
  bit   m_accepted;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic ins_t empty_ins();
    ins_t e;
    e.v = 0; e.wr = 0; e.ld = 0; e.cw = 0; e.rd = 0;
    return e;
  endfunction

  // Stage distance of the youngest in-flight writer of rs; -1 when none.
  function automatic int youngest(input int rs);
    for (int s = 0; s < 3; s++)
      if (rs != 0 && pipe[s].v && pipe[s].wr && pipe[s].rd == rs) return s;
    return -1;
  endfunction

  task automatic model_step(input stim_t s, output exp_t e);
    int  y1, y2;
    bit  dh, ch, csr_inflight, fwd_on;
    ins_t nw;
    y1 = s.r1 ? youngest(s.rs1) : -1;
    y2 = s.r2 ? youngest(s.rs2) : -1;
`ifdef YSYX_22041461_FWD_EN
    fwd_on = 1;
    dh = ((y1 == 0) || (y2 == 0)) && pipe[0].ld;
`else
    fwd_on = 0;
    dh = (y1 >= 0) || (y2 >= 0);
`endif
    csr_inflight = 0;
    for (int k = 0; k < 3; k++) if (pipe[k].v && pipe[k].cw) csr_inflight = 1;
    ch = (s.cr || s.cw) && csr_inflight;
    e.f1 = 0; e.f2 = 0; e.cnt = m_cnt;
    m_accepted = 0;
    nw = empty_ins();
    if (s.valid) begin nw.v = 1; nw.wr = s.wr; nw.rd = s.rd; nw.ld = s.ld; nw.cw = s.cw; end

    if (s.trap) begin
      e.ctrl = 9'b111111111;
      for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
      m_pend = 0;
    end else if (s.mb) begin
      e.ctrl = 9'b000000011;
      pipe[2] = empty_ins();
      if (s.redir) m_pend = 1;
    end else if (s.eb) begin
      e.ctrl = 9'b000001110;
      pipe[2] = pipe[1];
      pipe[1] = empty_ins();
    end else if (s.redir || m_pend) begin
      e.ctrl = 9'b111111010;
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = empty_ins();
      m_pend = 0;
    end else if (s.valid && (dh || ch)) begin
      e.ctrl = 9'b000111010;
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = empty_ins();
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      e.ctrl = 9'b110101010;
      if (fwd_on && s.valid) begin
        e.f1 = y1 + 1;
        e.f2 = y2 + 1;
      end
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = nw;
      m_accepted = 1;
    end

    if (s.rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
      m_pend = 0;
      m_cnt = 0;
    end
  endtask

  function automatic stim_t nop();
    stim_t s;
    s.rst = 0; s.valid = 0; s.r1 = 0; s.r2 = 0; s.wr = 0; s.ld = 0; s.cr = 0; s.cw = 0;
    s.eb = 0; s.mb = 0; s.redir = 0; s.trap = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
    return s;
  endfunction

  function automatic stim_t alu(input int rd, input int rs1, input int rs2);
    stim_t s = nop();
    s.valid = 1; s.wr = 1; s.rd = rd;
    s.r1 = 1; s.rs1 = rs1; s.r2 = 1; s.rs2 = rs2;
    return s;
  endfunction

  function automatic stim_t ldi(input int rd, input int rs1);
    stim_t s = nop();
    s.valid = 1; s.wr = 1; s.rd = rd; s.ld = 1; s.r1 = 1; s.rs1 = rs1;
    return s;
  endfunction

  function automatic stim_t csri(input bit w, input bit r);
    stim_t s = nop();
    s.valid = 1; s.cw = w; s.cr = r;
    return s;
  endfunction

  task automatic issue(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    rst = s.rst; ID_valid = s.valid; ID_rs1_read = s.r1; ID_rs2_read = s.r2;
    ID_rs1 = 5'(s.rs1); ID_rs2 = 5'(s.rs2); ID_rd_write = s.wr; ID_rd = 5'(s.rd);
    ID_is_load = s.ld; ID_csr_read = s.cr; ID_csr_write = s.cw;
    EXE_busy = s.eb; MEM_busy = s.mb; EXE_redirect = s.redir; trap_flush = s.trap;
    model_step(s, e);
    q.push_back(e);
  endtask

  // Hold an instruction in ID until it is accepted (bounded).
  task automatic send(input stim_t s);
    for (int n = 0; n < 20; n++) begin
      issue(s);
      if (m_accepted) return;
    end
    chk("send_accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(nop());
  endtask

  // Monitor: the outputs are valid every cycle; compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", int'({IF_enable, ID_enable, ID_flush, EXE_enable, EXE_bubble,
                          MEM_enable, MEM_bubble, WB_enable, WB_bubble}), int'(e.ctrl));
        chk("fwd_rs1_sel", int'(fwd_rs1_sel), e.f1);
        chk("fwd_rs2_sel", int'(fwd_rs2_sel), e.f2);
        chk("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1; ID_valid = 0; ID_rs1_read = 0; ID_rs2_read = 0; ID_rs1 = '0; ID_rs2 = '0;
    ID_rd_write = 0; ID_rd = '0; ID_is_load = 0; ID_csr_read = 0; ID_csr_write = 0;
    EXE_busy = 0; MEM_busy = 0; EXE_redirect = 0; trap_flush = 0;
    for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
    m_pend = 0; m_cnt = 0; m_accepted = 0;
    repeat (2) @(posedge clk);

    idle(3);
    send(alu(5, 1, 2)); send(alu(6, 5, 0)); idle(4);     // ALU -> dependent ALU
    send(ldi(7, 1)); send(alu(8, 0, 7)); idle(4);        // load-use
    send(alu(0, 1, 2)); send(alu(9, 0, 0)); idle(4);     // x0 never hazards
    send(csri(1, 0)); send(csri(0, 1)); idle(4);         // CSR serialisation

    // MEM_busy for 4 cycles with a redirect seen in cycle 2
    s = nop(); s.mb = 1;
    issue(s); s.redir = 1; issue(s); s.redir = 0; issue(s); issue(s);
    idle(2);

    // trap together with a data hazard, then the same consumer again
    send(alu(5, 0, 0));
    s = alu(6, 5, 5); s.trap = 1; issue(s);
    send(alu(6, 5, 5)); idle(3);

    // reset in the middle of a stall
    send(alu(4, 0, 0)); s = alu(3, 4, 0); issue(s); s.rst = 1; issue(s); idle(3);

    // drive the (narrow) stall counter into saturation
    for (int i = 0; i < 16; i++) begin send(ldi(2, 0)); send(alu(3, 2, 0)); end
    idle(4);

    for (int i = 0; i < 400; i++) begin
      s = nop();
      s.valid = ($urandom_range(0, 3) != 0);
      s.r1 = $urandom_range(0, 1); s.r2 = $urandom_range(0, 1);
      s.rs1 = $urandom_range(0, 3); s.rs2 = $urandom_range(0, 3);
      s.wr = $urandom_range(0, 1); s.rd = $urandom_range(0, 3);
      s.ld = ($urandom_range(0, 2) == 0);
      s.cr = ($urandom_range(0, 7) == 0); s.cw = ($urandom_range(0, 7) == 0);
      s.eb = ($urandom_range(0, 7) == 0); s.mb = ($urandom_range(0, 7) == 0);
      s.redir = ($urandom_range(0, 7) == 0); s.trap = ($urandom_range(0, 31) == 0);
      s.rst = ($urandom_range(0, 99) == 0);
      issue(s);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
